// File: rtl/c7bifu_ibuf.sv
// ----------------------------------------------------------------------------
// c7bifu_ibuf -- fetch-to-decode instruction buffer for the c7b IFU.
//
// Circular buffer of DEPTH entries {pc, inst, exc_vld, exc_code} between the
// fetch return path and decode. The oldest entry is presented to decode and
// consumed in the same cycle it is shown valid. There is no combinational
// fetch-to-decode path: a push becomes visible one cycle later at the earliest.
//
// Parameters:
//   DEPTH      entries, power of two, >= 2
//   PC_W       PC width
//   AF_MARGIN  almost-full when occupancy >= DEPTH-AF_MARGIN (0..DEPTH-1)
//
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_stall                  decode stall; head entry held
//   i_flush                  discard all entries and the current push
//   i_inst_vld_f ..          fetch offer: valid, PC, instruction, exception
//   o_ibuf_rdy_f             buffer accepts a push this cycle
//   o_ibuf_afull_f           almost-full, for fetch throttling
//   o_ibuf_cnt               current occupancy
//   o_ibuf_vld_d             head valid and consumed this cycle
//   o_ibuf_pc_d .. code_d    head entry (zero when empty)
//
// Optional feature macro: C7BIFU_IBUF_FULL_PASS_EN
//   When defined, a full buffer accepts a push in a cycle where it also pops,
//   keeping 1/cycle throughput at the cost of a stall-to-ready comb path.
// ----------------------------------------------------------------------------
module c7bifu_ibuf #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PC_W      = 32,
    parameter int unsigned AF_MARGIN = 1
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_stall,
    input  logic                         i_flush,
    input  logic                         i_inst_vld_f,
    input  logic [PC_W-1:0]              i_inst_addr_f,
    input  logic [31:0]                  i_inst_f,
    input  logic                         i_fetch_exc_vld_f,
    input  logic [5:0]                   i_fetch_exc_code_f,
    output logic                         o_ibuf_rdy_f,
    output logic                         o_ibuf_afull_f,
    output logic [$clog2(DEPTH+1)-1:0]   o_ibuf_cnt,
    output logic                         o_ibuf_vld_d,
    output logic [PC_W-1:0]              o_ibuf_pc_d,
    output logic [31:0]                  o_ibuf_inst_d,
    output logic                         o_ibuf_exc_vld_d,
    output logic [5:0]                   o_ibuf_exc_code_d
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Storage is deliberately not reset; outputs are gated by occupancy.
    logic [PC_W-1:0]  r_pc       [DEPTH];
    logic [31:0]      r_inst     [DEPTH];
    logic             r_exc_vld  [DEPTH];
    logic [5:0]       r_exc_code [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_rdy;
    logic             w_push;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CNT_W'(DEPTH));
    assign w_pop   = ~w_empty & ~i_stall & ~i_flush;

`ifdef C7BIFU_IBUF_FULL_PASS_EN
    // A full buffer frees its head slot this cycle when it pops.
    assign w_rdy = ~w_full | w_pop;
`else
    assign w_rdy = ~w_full;
`endif

    assign w_push = i_inst_vld_f & w_rdy & ~i_flush;

    always_comb begin
        w_cnt_nxt = r_cnt;
        unique case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
            2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // Pointers and occupancy; reset beats flush beats push/pop.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_cnt <= w_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push && !i_reset) begin
            r_pc[r_wr_ptr]       <= i_inst_addr_f;
            r_inst[r_wr_ptr]     <= i_inst_f;
            r_exc_vld[r_wr_ptr]  <= i_fetch_exc_vld_f;
            r_exc_code[r_wr_ptr] <= i_fetch_exc_code_f;
        end
    end

    always_comb begin
        o_ibuf_pc_d       = '0;
        o_ibuf_inst_d     = '0;
        o_ibuf_exc_vld_d  = 1'b0;
        o_ibuf_exc_code_d = '0;
        if (!w_empty) begin
            o_ibuf_pc_d       = r_pc[r_rd_ptr];
            o_ibuf_inst_d     = r_inst[r_rd_ptr];
            o_ibuf_exc_vld_d  = r_exc_vld[r_rd_ptr] & w_pop;
            o_ibuf_exc_code_d = r_exc_code[r_rd_ptr];
        end
    end

    assign o_ibuf_vld_d   = w_pop;
    assign o_ibuf_rdy_f   = w_rdy;
    assign o_ibuf_cnt     = r_cnt;
    assign o_ibuf_afull_f = (32'(r_cnt) >= (DEPTH - AF_MARGIN));

endmodule

// File: tb/tb_c7bifu_ibuf.sv
module tb_c7bifu_ibuf;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned PC_W      = 32;
    localparam int unsigned AF_MARGIN = 1;
    localparam int unsigned CNT_W     = 3;

`ifdef C7BIFU_IBUF_FULL_PASS_EN
    localparam bit FullPass = 1'b1;
`else
    localparam bit FullPass = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             stall;
    logic             flush;
    logic             inst_vld_f;
    logic [PC_W-1:0]  inst_addr_f;
    logic [31:0]      inst_f;
    logic             exc_vld_f;
    logic [5:0]       exc_code_f;
    logic             rdy_f;
    logic             afull_f;
    logic [CNT_W-1:0] cnt;
    logic             vld_d;
    logic [PC_W-1:0]  pc_d;
    logic [31:0]      inst_d;
    logic             exc_vld_d;
    logic [5:0]       exc_code_d;

    c7bifu_ibuf #(
        .DEPTH     (DEPTH),
        .PC_W      (PC_W),
        .AF_MARGIN (AF_MARGIN)
    ) dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_stall            (stall),
        .i_flush            (flush),
        .i_inst_vld_f       (inst_vld_f),
        .i_inst_addr_f      (inst_addr_f),
        .i_inst_f           (inst_f),
        .i_fetch_exc_vld_f  (exc_vld_f),
        .i_fetch_exc_code_f (exc_code_f),
        .o_ibuf_rdy_f       (rdy_f),
        .o_ibuf_afull_f     (afull_f),
        .o_ibuf_cnt         (cnt),
        .o_ibuf_vld_d       (vld_d),
        .o_ibuf_pc_d        (pc_d),
        .o_ibuf_inst_d      (inst_d),
        .o_ibuf_exc_vld_d   (exc_vld_d),
        .o_ibuf_exc_code_d  (exc_code_d)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [5:0]  code;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   clr_pending = 1'b0;
    bit   mon_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every consumed head must match the oldest expected push.
    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en && vld_d === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL head_unexpected: got pc %0h inst %0h expected no entry",
                         pc_d, inst_d);
            end else begin
                e = q.pop_front();
                if (pc_d !== e.pc || inst_d !== e.inst || exc_vld_d !== e.exc ||
                    exc_code_d !== e.code) begin
                    errors++;
                    $display("FAIL head_data: got pc %0h inst %0h exc %0b code %0h expected pc %0h inst %0h exc %0b code %0h",
                             pc_d, inst_d, exc_vld_d, exc_code_d, e.pc, e.inst, e.exc, e.code);
                end
            end
        end
    end

    // One cycle: drive after the edge, return at the following negedge for checks.
    task automatic cyc(input bit rst, input bit vld, input logic [31:0] pc,
                       input logic [31:0] ins, input bit exc, input logic [5:0] code,
                       input bit stl, input bit fl, input bit acc);
        @(posedge clk);
        #1;
        if (clr_pending) begin
            q.delete();
            clr_pending = 1'b0;
        end
        reset       = rst;
        inst_vld_f  = vld;
        inst_addr_f = pc;
        inst_f      = ins;
        exc_vld_f   = exc;
        exc_code_f  = code;
        stall       = stl;
        flush       = fl;
        if (fl) q.delete();
        if (acc) q.push_back({pc, ins, exc, code});
        if (rst) clr_pending = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input bit stl);
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 6'h0, stl, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ins, input bit stl,
                        input bit acc);
        cyc(1'b0, 1'b1, pc, ins, 1'b0, 6'h0, stl, 1'b0, acc);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; inst_vld_f = 1'b0;
        inst_addr_f = '0; inst_f = '0; exc_vld_f = 1'b0; exc_code_f = '0;

        // Reset state
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 6'h0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 6'h0, 1'b0, 1'b0, 1'b0);
        chk("rst_rdy", 64'(rdy_f), 64'h1);
        chk("rst_afull", 64'(afull_f), 64'h0);
        chk("rst_cnt", 64'(cnt), 64'h0);
        chk("rst_vld", 64'(vld_d), 64'h0);
        chk("rst_pc", 64'(pc_d), 64'h0);
        chk("rst_inst", 64'(inst_d), 64'h0);
        chk("rst_exc", 64'(exc_vld_d), 64'h0);
        chk("rst_code", 64'(exc_code_d), 64'h0);
        mon_en = 1'b1;

        // Single instruction, one-cycle latency, no forwarding when empty
        push(32'h1c000000, 32'h02800c21, 1'b0, 1'b1);
        chk("t1_nofwd_vld", 64'(vld_d), 64'h0);
        chk("t1_nofwd_cnt", 64'(cnt), 64'h0);
        idle(1'b0);
        chk("t1_vld", 64'(vld_d), 64'h1);
        chk("t1_cnt", 64'(cnt), 64'h1);
        chk("t1_pc", 64'(pc_d), 64'h1c000000);
        idle(1'b0);
        chk("t1_empty_cnt", 64'(cnt), 64'h0);
        chk("t1_empty_vld", 64'(vld_d), 64'h0);

        // Fill under stall, watch almost-full and ready
        for (int i = 0; i < 4; i++) begin
            push(32'h100 + 32'(4 * i), 32'haa000000 + 32'(i), 1'b1, 1'b1);
            chk("t2_fill_cnt", 64'(cnt), 64'(i));
            chk("t2_fill_afull", 64'(afull_f), 64'(i >= 3));
        end
        idle(1'b1);
        chk("t2_full_cnt", 64'(cnt), 64'h4);
        chk("t2_full_rdy", 64'(rdy_f), 64'h0);
        chk("t2_full_afull", 64'(afull_f), 64'h1);
        chk("t2_stall_vld", 64'(vld_d), 64'h0);
        chk("t2_stall_pc", 64'(pc_d), 64'h100);
        for (int i = 0; i < 4; i++) begin
            idle(1'b0);
            chk("t2_drain_vld", 64'(vld_d), 64'h1);
            chk("t2_drain_cnt", 64'(cnt), 64'(4 - i));
            if (i == 0) chk("t2_pop_rdy", 64'(rdy_f), 64'(FullPass));
        end
        idle(1'b0);
        chk("t2_drained_cnt", 64'(cnt), 64'h0);

        // Streaming with wrapped pointers: push and pop in the same cycle
        for (int i = 0; i < 4; i++) begin
            push(32'h110 + 32'(4 * i), 32'hbb000000 + 32'(i), 1'b0, 1'b1);
            chk("t2_stream_cnt", 64'(cnt), 64'(i != 0));
            chk("t2_stream_vld", 64'(vld_d), 64'(i != 0));
        end
        idle(1'b0);
        chk("t2_stream_tail", 64'(vld_d), 64'h1);
        idle(1'b0);
        chk("t2_stream_empty", 64'(cnt), 64'h0);

        // Full buffer offered a push while popping
        for (int i = 0; i < 4; i++) push(32'h200 + 32'(4 * i), 32'hcc000000 + 32'(i), 1'b1, 1'b1);
        push(32'h210, 32'hcc000004, 1'b0, FullPass);
        chk("t3_full_rdy", 64'(rdy_f), 64'(FullPass));
        chk("t3_full_vld", 64'(vld_d), 64'h1);
        idle(1'b1);
        chk("t3_after_cnt", 64'(cnt), FullPass ? 64'h4 : 64'h3);
        for (int i = 0; i < 5; i++) idle(1'b0);
        chk("t3_drained_cnt", 64'(cnt), 64'h0);

        // Flush with stall and a same-cycle push
        for (int i = 0; i < 3; i++) push(32'h300 + 32'(4 * i), 32'hdd000000 + 32'(i), 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 32'h3ff, 32'hdeadbeef, 1'b0, 6'h0, 1'b1, 1'b1, 1'b0);
        chk("t4_flush_vld", 64'(vld_d), 64'h0);
        chk("t4_flush_cnt", 64'(cnt), 64'h3);
        idle(1'b0);
        chk("t4_post_cnt", 64'(cnt), 64'h0);
        chk("t4_post_rdy", 64'(rdy_f), 64'h1);
        chk("t4_post_pc", 64'(pc_d), 64'h0);
        chk("t4_post_inst", 64'(inst_d), 64'h0);
        idle(1'b0);

        // Exception entry, stall 1,1,0
        cyc(1'b0, 1'b1, 32'h400, 32'hee000000, 1'b1, 6'h08, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        chk("t5_exc0", 64'(exc_vld_d), 64'h0);
        chk("t5_code0", 64'(exc_code_d), 64'h08);
        idle(1'b1);
        chk("t5_exc1", 64'(exc_vld_d), 64'h0);
        chk("t5_code1", 64'(exc_code_d), 64'h08);
        idle(1'b0);
        chk("t5_exc2", 64'(exc_vld_d), 64'h1);
        chk("t5_code2", 64'(exc_code_d), 64'h08);
        idle(1'b0);
        chk("t5_empty_cnt", 64'(cnt), 64'h0);

        // Reset mid-stream
        push(32'h500, 32'hff000000, 1'b1, 1'b1);
        push(32'h504, 32'hff000001, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 6'h0, 1'b0, 1'b0, 1'b0);
        chk("t6_rst_cyc_vld", 64'(vld_d), 64'h1);
        chk("t6_rst_cyc_cnt", 64'(cnt), 64'h2);
        idle(1'b0);
        chk("t6_post_cnt", 64'(cnt), 64'h0);
        chk("t6_post_vld", 64'(vld_d), 64'h0);
        chk("t6_post_rdy", 64'(rdy_f), 64'h1);
        idle(1'b0);

        chk("sb_drained", 64'(q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
